// File: rtl/sparse_config_sequencer.sv
// sparse_config_sequencer: streams a {addr,data} bitstream onto the config bus, releases stall/flush, then times the run
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   start                  begin a sequence (honoured only in IDLE, DONE or TIMEOUT)
//   bs_size, timeout_limit word count (clamped to BS_DEPTH) and run-cycle limit (0 = none), latched with start
//   bs_rd_en/addr/data     bitstream memory read port, data returned one cycle after bs_rd_en
//   config_*               config bus towards the array; config_read is tied low
//   stall, flush, dut_done array control and completion
//   cycle_count            RUN cycles elapsed
//   busy, done, timed_out  sequence status; done and timed_out stay set until the next start
module sparse_config_sequencer #(
    parameter int BS_DEPTH   = 4096,
    parameter int BS_IDX_W   = 12,
    parameter int FLUSH_PRE  = 16,
    parameter int FLUSH_POST = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BS_IDX_W:0]   bs_size,
    input  logic [31:0]         timeout_limit,
    output logic                bs_rd_en,
    output logic [BS_IDX_W-1:0] bs_rd_addr,
    input  logic [63:0]         bs_rd_data,
    output logic [31:0]         config_config_addr,
    output logic [31:0]         config_config_data,
    output logic                config_write,
    output logic                config_read,
    output logic                stall,
    output logic                flush,
    input  logic                dut_done,
    output logic [63:0]         cycle_count,
    output logic                busy,
    output logic                done,
    output logic                timed_out
);
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH_STALLED, FLUSH_RUN, RUN, DONE, TIMEOUT} state_t;
    localparam logic [BS_IDX_W:0] DEPTH = BS_DEPTH[BS_IDX_W:0];
    localparam logic [31:0] PRE_LAST  = 32'(FLUSH_PRE - 1);
    localparam logic [31:0] POST_LAST = 32'(FLUSH_POST - 1);
    state_t state, state_next;
    logic [BS_IDX_W:0] size_lat, size_clamped;
    logic [31:0] limit_lat;
    logic [31:0] phase_cnt;
    logic rd_valid;
    logic accept, last_rd, timeout_hit;
    assign config_read = 1'b0;
    always_comb begin
        size_clamped = (bs_size > DEPTH) ? DEPTH : bs_size;
        accept = start && (state == IDLE || state == DONE || state == TIMEOUT);
        last_rd = {1'b0, bs_rd_addr} == size_lat - 1'b1;
        timeout_hit = (limit_lat != '0) && (cycle_count + 64'd1 == {32'd0, limit_lat});
    end
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE, TIMEOUT: state_next = accept ? ((size_clamped == '0) ? FLUSH_STALLED : LOAD) : state;
            // reads and the write pipeline have both drained once neither stage is active
            LOAD:          state_next = (!bs_rd_en && !rd_valid) ? FLUSH_STALLED : LOAD;
            FLUSH_STALLED: state_next = (phase_cnt == PRE_LAST) ? FLUSH_RUN : FLUSH_STALLED;
            FLUSH_RUN:     state_next = (phase_cnt == POST_LAST) ? RUN : FLUSH_RUN;
            RUN:           state_next = dut_done ? DONE : (timeout_hit ? TIMEOUT : RUN);
            default:       state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            phase_cnt          <= '0;
            size_lat           <= '0;
            limit_lat          <= '0;
            rd_valid           <= 1'b0;
            bs_rd_en           <= 1'b0;
            bs_rd_addr         <= '0;
            config_write       <= 1'b0;
            config_config_addr <= '0;
            config_config_data <= '0;
            stall              <= 1'b1;
            flush              <= 1'b0;
            cycle_count        <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            timed_out          <= 1'b0;
        end else begin
            state        <= state_next;
            phase_cnt    <= (state_next != state) ? '0 : phase_cnt + 32'd1;
            stall        <= !(state_next == FLUSH_RUN || state_next == RUN);
            flush        <= state_next == FLUSH_STALLED || state_next == FLUSH_RUN;
            busy         <= state_next inside {LOAD, FLUSH_STALLED, FLUSH_RUN, RUN};
            done         <= state_next == DONE;
            timed_out    <= state_next == TIMEOUT;
            rd_valid     <= bs_rd_en;
            config_write <= rd_valid;
            if (rd_valid) {config_config_addr, config_config_data} <= bs_rd_data;
            if (accept) begin
                size_lat    <= size_clamped;
                limit_lat   <= timeout_limit;
                cycle_count <= '0;
                bs_rd_en    <= size_clamped != '0;
                bs_rd_addr  <= '0;
            end else if (bs_rd_en) begin
                bs_rd_en   <= !last_rd;
                bs_rd_addr <= last_rd ? bs_rd_addr : bs_rd_addr + 1'b1;
            end
            // the deciding cycle is not counted when the array reports done
            if (state == RUN && !dut_done) cycle_count <= cycle_count + 64'd1;
        end
    end
endmodule

// File: tb/tb_sparse_config_sequencer.sv
// tb_sparse_config_sequencer: directed vectors for the config load, flush release and run timing
module tb_sparse_config_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [12:0] bs_size = '0;
    logic [31:0] timeout_limit = '0;
    logic bs_rd_en;
    logic [11:0] bs_rd_addr;
    logic [63:0] bs_rd_data = '0;
    logic [31:0] config_config_addr, config_config_data;
    logic config_write, config_read, stall, flush;
    logic dut_done = 1'b0;
    logic [63:0] cycle_count;
    logic busy, done, timed_out;
    logic [63:0] mem [0:7];
    logic [31:0] exp_addr [0:2];
    logic [31:0] exp_data [0:2];
    logic [63:0] wr, fl, st, rd;
    int nwr;
    int vectors = 0;
    int miscompares = 0;
    sparse_config_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .bs_size(bs_size), .timeout_limit(timeout_limit),
        .bs_rd_en(bs_rd_en), .bs_rd_addr(bs_rd_addr), .bs_rd_data(bs_rd_data),
        .config_config_addr(config_config_addr), .config_config_data(config_config_data),
        .config_write(config_write), .config_read(config_read), .stall(stall), .flush(flush),
        .dut_done(dut_done), .cycle_count(cycle_count), .busy(busy), .done(done), .timed_out(timed_out)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (bs_rd_en) bs_rd_data <= mem[bs_rd_addr[2:0]];
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic start_seq(input logic [12:0] size, input logic [31:0] lim);
        start = 1'b1;
        bs_size = size;
        timeout_limit = lim;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic run_trace(input int last, input int done_at, input int glitch_at, input int spur_at);
        wr = '0; fl = '0; st = '0; rd = '0; nwr = 0;
        for (int c = 1; c <= last; c++) begin
            wr[c] = config_write;
            fl[c] = flush;
            st[c] = stall;
            rd[c] = bs_rd_en;
            if (config_write) begin
                if (nwr < 3) begin
                    check("cfg_addr", 64'(config_config_addr), 64'(exp_addr[nwr]));
                    check("cfg_data", 64'(config_config_data), 64'(exp_data[nwr]));
                end
                nwr++;
            end
            dut_done = (c == done_at) || (c == glitch_at);
            start = (c == spur_at);
            bs_size = 13'd3;
            @(negedge clk);
        end
        dut_done = 1'b0;
        start = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[0] = {32'h0001_0000, 32'h0000_000A};
        mem[1] = {32'h0002_0000, 32'h0000_000B};
        mem[2] = {32'h0003_0000, 32'h0000_000C};
        exp_addr[0] = 32'h0001_0000; exp_data[0] = 32'hA;
        exp_addr[1] = 32'h0002_0000; exp_data[1] = 32'hB;
        exp_addr[2] = 32'h0003_0000; exp_data[2] = 32'hC;
        repeat (2) @(negedge clk);
        check("rst_ctl", 64'({stall, flush, config_write, config_read, bs_rd_en, busy, done, timed_out}), 64'h80);
        check("rst_addr", 64'({config_config_addr, config_config_data}), 64'd0);
        check("rst_rdaddr", 64'(bs_rd_addr), 64'd0);
        check("rst_count", cycle_count, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        // 3-word load, dut_done glitch during flush ignored, done in 10th RUN cycle
        start_seq(13'd3, 32'd0);
        check("busy_rise", 64'(busy), 64'd1);
        run_trace(33, 33, 10, 0);
        check("t1_wr", wr, 64'h38);
        check("t1_flush", fl, 64'hFF_FFC0);
        check("t1_stall", st, 64'h3F_FFFE);
        check("t1_rd", rd, 64'hE);
        check("t1_nwr", 64'(nwr), 64'd3);
        check("t1_status", 64'({done, timed_out, stall, busy, flush}), 64'b10100);
        check("t1_count", cycle_count, 64'd9);
        // timeout after 5 RUN cycles
        start_seq(13'd3, 32'd5);
        check("done_clr", 64'({done, busy}), 64'b01);
        run_trace(28, 0, 0, 0);
        check("t3_stall", st, 64'h3F_FFFE);
        check("t3_status", 64'({done, timed_out, stall, busy, flush}), 64'b01100);
        check("t3_count", cycle_count, 64'd5);
        // done and timeout decided in the same cycle
        start_seq(13'd3, 32'd5);
        check("tout_clr", 64'(timed_out), 64'd0);
        run_trace(28, 28, 0, 0);
        check("t6_status", 64'({done, timed_out, stall, busy}), 64'b1010);
        check("t6_count", cycle_count, 64'd4);
        // empty bitstream, start pulse while busy ignored
        start_seq(13'd0, 32'd0);
        run_trace(22, 22, 0, 5);
        check("t4_wr", wr, 64'd0);
        check("t4_flush", fl, 64'h7_FFFE);
        check("t4_stall", st, 64'h1_FFFE);
        check("t4_rd", rd, 64'd0);
        check("t4_status", 64'({done, timed_out, busy}), 64'b100);
        check("t4_count", cycle_count, 64'd3);
        // reset in the 2nd write cycle, then a full reload from index 0
        start_seq(13'd3, 32'd0);
        run_trace(3, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_ctl", 64'({config_write, stall, busy, flush, bs_rd_en, done}), 64'b010000);
        check("t5_rst_addr", 64'(config_config_addr), 64'd0);
        reset = 1'b0;
        start_seq(13'd3, 32'd0);
        run_trace(8, 0, 0, 0);
        check("t5_wr", wr, 64'h38);
        check("t5_rd", rd, 64'hE);
        check("t5_nwr", 64'(nwr), 64'd3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sparse_config_sequencer.md
# sparse_config_sequencer

Hardware sequencer that loads a CGRA configuration bitstream into the sparse-array top and brings it into execution. It streams 64-bit {addr, data} words from a bitstream memory onto the config bus, then runs the stall/flush release sequence, then counts run cycles until the array reports done or a timeout expires. It sits between a bitstream SRAM and the `config_*`/`stall`/`flush`/`done` pins of the sparse tile array.

## Interface
Parameters:
- BS_DEPTH, 4096, bitstream memory depth in words
- BS_IDX_W, 12, bitstream index width (log2 BS_DEPTH)
- FLUSH_PRE, 16, cycles flush is held with stall high
- FLUSH_POST, 2, cycles flush is held after stall drops

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin sequence; sampled only in IDLE, DONE or TIMEOUT
- bs_size  in  BS_IDX_W+1  number of words to load, 0..BS_DEPTH; sampled with start
- timeout_limit  in  32  maximum RUN cycles; 0 disables timeout; sampled with start
- bs_rd_en  out  1  bitstream memory read enable
- bs_rd_addr  out  BS_IDX_W  bitstream word index
- bs_rd_data  in  64  read data, valid 1 cycle after bs_rd_en; [63:32] is addr, [31:0] is data
- config_config_addr  out  32  config address
- config_config_data  out  32  config data
- config_write  out  1  config write strobe
- config_read  out  1  tied to 0
- stall  out  1  array stall
- flush  out  1  array flush
- dut_done  in  1  array completion flag
- cycle_count  out  64  RUN cycles elapsed
- busy  out  1  high from the cycle after start until DONE or TIMEOUT
- done  out  1  sticky, array finished
- timed_out  out  1  sticky, timeout hit

## Operation
- States: IDLE → LOAD → FLUSH_STALLED → FLUSH_RUN → RUN → DONE | TIMEOUT. DONE and TIMEOUT return to LOAD on start.
- Reset values: state IDLE; stall=1; flush=0; config_write=0; config_read=0; config_config_addr=0; config_config_data=0; bs_rd_en=0; bs_rd_addr=0; cycle_count=0; busy=0; done=0; timed_out=0.
- A start clears done, timed_out and cycle_count, latches bs_size and timeout_limit, and asserts busy.
- LOAD: reads indices 0..N-1 on consecutive cycles, one per cycle. Each returned word is registered onto config_config_addr/data with config_write=1. Writes occur on N consecutive cycles with no gaps. Addr/data hold their last value after config_write drops. stall=1 and flush=0 throughout.
- FLUSH_STALLED: flush=1, stall=1 for FLUSH_PRE cycles.
- FLUSH_RUN: flush=1, stall=0 for FLUSH_POST cycles.
- RUN: flush=0, stall=0. cycle_count increments on every RUN cycle.
- RUN exits:
  - dut_done high → DONE: done=1, cycle_count frozen.
  - Otherwise, timeout_limit≠0 and cycle_count reaches timeout_limit → TIMEOUT: timed_out=1.
  - dut_done and timeout in the same cycle → DONE wins.
- In DONE/TIMEOUT: stall=1, flush=0, busy=0.
- start while busy is ignored.
- bs_size > BS_DEPTH is clamped to BS_DEPTH.
- dut_done is ignored outside RUN.

## Timing
- Cycle 0 is the cycle in which start is sampled high.
- N≥1:
  - bs_rd_en=1 with bs_rd_addr=i in cycle 1+i.
  - config_write=1 carrying word i in cycle 3+i.
  - FLUSH_STALLED occupies cycles N+3 .. N+2+FLUSH_PRE.
  - FLUSH_RUN follows.
  - First RUN cycle is N+3+FLUSH_PRE+FLUSH_POST.
- N=0: no reads or writes; FLUSH_STALLED starts in cycle 1.
- All outputs are registered. done/timed_out rise in the cycle after the deciding RUN cycle.
- cycle_count at DONE equals the number of RUN cycles before the one in which dut_done was sampled high.
- Reset asserted mid-sequence: all outputs take reset values at the next edge, config_write drops immediately, and any in-flight read data is discarded.

## Test plan
- Memory holds words {0x00010000,0xA}, {0x00020000,0xB}, {0x00030000,0xC}; bs_size=3; FLUSH_PRE=16, FLUSH_POST=2 → writes in cycles 3,4,5 with exactly those addr/data pairs; flush high cycles 6–23; stall low from cycle 22; first RUN cycle 24.
- Same load, dut_done raised in the 10th RUN cycle → done=1 next cycle; cycle_count=9; stall=1; busy=0.
- timeout_limit=5, dut_done never asserted → timed_out=1 after 5 RUN cycles; cycle_count=5; done=0.
- bs_size=0 → no config_write pulses; flush rises in cycle 1; start pulses while busy are ignored.
- reset asserted in the 2nd write cycle of a 3-word load → config_write=0, stall=1, busy=0 next cycle; a subsequent start reloads all 3 words from index 0.
- dut_done and the timeout condition in the same cycle → done=1, timed_out=0.
